// File: rtl/package_framer_ctrl.sv
// Package framer: pops response-FIFO bytes, validates package framing and packs PACKAGE_NUM payloads into one window word.
// Optional checksum checking is enabled by defining PACKAGE_FRAMER_CHKSUM_EN.
module package_framer_ctrl #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    PACKAGE_SIZE = 11,
  parameter int                    PACKAGE_NUM  = 4,
  parameter logic [DATA_WIDTH-1:0] START_BYTE   = 8'h55,
  parameter logic [DATA_WIDTH-1:0] FUNC_BASE    = 8'h51,
  parameter int                    WINDOW_WIDTH = 256,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_r_en,
  input  logic [DATA_WIDTH-1:0]   fifo_data_o,
  input  logic                    fifo_data_o_vld,
  output logic [WINDOW_WIDTH-1:0] win_data_o,
  output logic                    win_wen_o,
  output logic [CNT_WIDTH-1:0]    frame_cnt_o,
  output logic [7:0]              func_err_cnt_o,
  output logic [7:0]              chk_err_cnt_o,
  output logic                    busy_o
);

  localparam int BIDX_W = $clog2(PACKAGE_SIZE);
  localparam int PIDX_W = $clog2(PACKAGE_NUM + 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(PACKAGE_SIZE - 4);
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(PACKAGE_NUM - 1);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_FUNC    = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;

  logic [2:0]              state;
  logic [PIDX_W-1:0]       pkg_idx;
  logic [BIDX_W-1:0]       byte_idx;
  logic                    rd_pend;
  logic [WINDOW_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0]   func_exp;
  logic                    chk_ok;
  logic                    going_emit;
  logic                    issue;

  assign func_exp   = FUNC_BASE + DATA_WIDTH'(pkg_idx);
  assign going_emit = fifo_data_o_vld && (state == S_CHECK) && chk_ok && (pkg_idx == PIDX_LAST);
  // A pop may be issued on the same edge the previous byte lands, giving 1 byte per 2 cycles;
  // suppressing it on the final checksum keeps the EMIT cycle free of pops.
  assign issue  = !fifo_empty && (!rd_pend || fifo_data_o_vld) && (state != S_EMIT) && !going_emit;
  assign busy_o = (state != S_HUNT) || (pkg_idx != '0);

`ifdef PACKAGE_FRAMER_CHKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  assign chk_ok = (fifo_data_o == sum);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum           <= '0;
      chk_err_cnt_o <= '0;
    end else if (fifo_data_o_vld) begin
      // sum is only meaningful from the start byte onward; HUNT reloads it
      sum <= (state == S_HUNT) ? fifo_data_o : sum + fifo_data_o;
      if ((state == S_CHECK) && !chk_ok && (chk_err_cnt_o != 8'hFF))
        chk_err_cnt_o <= chk_err_cnt_o + 1'b1;
    end
  end
`else
  assign chk_ok        = 1'b1;
  assign chk_err_cnt_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_HUNT;
      pkg_idx        <= '0;
      byte_idx       <= '0;
      rd_pend        <= 1'b0;
      fifo_r_en      <= 1'b0;
      shreg          <= '0;
      win_data_o     <= '0;
      win_wen_o      <= 1'b0;
      frame_cnt_o    <= '0;
      func_err_cnt_o <= '0;
    end else begin
      win_wen_o <= 1'b0;
      fifo_r_en <= issue;
      if (issue)
        rd_pend <= 1'b1;
      else if (fifo_data_o_vld)
        rd_pend <= 1'b0;

      case (state)
        S_HUNT: begin
          if (fifo_data_o_vld && (fifo_data_o == START_BYTE))
            state <= S_FUNC;
        end
        S_FUNC: begin
          if (fifo_data_o_vld) begin
            if (fifo_data_o == func_exp) begin
              byte_idx <= '0;
              state    <= S_PAYLOAD;
            end else begin
              if (func_err_cnt_o != 8'hFF)
                func_err_cnt_o <= func_err_cnt_o + 1'b1;
              pkg_idx <= '0;
              state   <= S_HUNT;
            end
          end
        end
        S_PAYLOAD: begin
          if (fifo_data_o_vld) begin
            shreg    <= {shreg[WINDOW_WIDTH-DATA_WIDTH-1:0], fifo_data_o};
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == BIDX_LAST)
              state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (fifo_data_o_vld) begin
            if (chk_ok) begin
              if (pkg_idx == PIDX_LAST) begin
                // The word is launched here so the strobe lands in the cycle after the checksum byte.
                win_data_o  <= shreg;
                win_wen_o   <= 1'b1;
                frame_cnt_o <= frame_cnt_o + 1'b1;
                pkg_idx     <= '0;
                state       <= S_EMIT;
              end else begin
                pkg_idx <= pkg_idx + 1'b1;
                state   <= S_HUNT;
              end
            end else begin
              pkg_idx <= '0;
              state   <= S_HUNT;
            end
          end
        end
        S_EMIT: begin
          state <= S_HUNT;
        end
        default: begin
          state   <= S_HUNT;
          pkg_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/package_framer_ctrl.md
Name: package_framer_ctrl

Overview:
- Sequences the Bluetooth response FIFO into the ThresholdCutterWindow write port.
- Pops bytes one at a time, hunts for the package start byte, and checks the function-byte order and the per-package checksum.
- Packs the payloads of PACKAGE_NUM consecutive valid packages into one WINDOW_WIDTH word, then pulses the window write enable once.
- Replaces the fixed-count window loader, so byte slips and corrupted packages never reach the window.

Parameters:
- DATA_WIDTH, 8, FIFO byte width.
- PACKAGE_SIZE, 11, bytes per package: start, func, 8 payload, checksum.
- PACKAGE_NUM, 4, packages per window word.
- START_BYTE, 8'h55, package start marker.
- FUNC_BASE, 8'h51, function byte expected for package 0; package k expects FUNC_BASE+k.
- WINDOW_WIDTH, 256, output word width; must equal PACKAGE_NUM*(PACKAGE_SIZE-3)*8.
- CNT_WIDTH, 16, width of frame_cnt.

Ports:
- clk  input  1  system clock (clk_50m domain).
- rst_n  input  1  synchronous, active-low reset.
- fifo_empty  input  1  response FIFO empty.
- fifo_r_en  output  1  one-cycle pop request.
- fifo_data_o  input  8  popped byte, valid with fifo_data_o_vld.
- fifo_data_o_vld  input  1  popped byte valid; arrives exactly 1 cycle after fifo_r_en.
- win_data_o  output  WINDOW_WIDTH  assembled window word.
- win_wen_o  output  1  one-cycle window write strobe.
- frame_cnt_o  output  CNT_WIDTH  count of emitted words, wraps.
- func_err_cnt_o  output  8  function-byte errors, saturating at 8'hFF.
- chk_err_cnt_o  output  8  checksum errors, saturating at 8'hFF.
- busy_o  output  1  high when state != HUNT or pkg_idx != 0.

Behaviour:
- Reset (rst_n==0 at posedge): fifo_r_en=0, win_wen_o=0, win_data_o=0, all counters=0, state=HUNT, pkg_idx=0, byte_idx=0, sum=0, read-outstanding flag=0. Reset dominates every other event; an in-progress word is discarded.
- Pop rule:
  - fifo_r_en=1 for one cycle when !fifo_empty and no read is outstanding, and state is not EMIT.
  - The outstanding flag clears on fifo_data_o_vld.
  - One byte in flight at most, so peak rate is 1 byte per 2 cycles.
  - fifo_r_en is never asserted while fifo_empty=1.
- A byte is "consumed" only on the cycle fifo_data_o_vld=1. All transitions below happen on consumption.
- State HUNT:
  - byte==START_BYTE: sum<=byte, go FUNC.
  - Any other byte is discarded; no counter changes.
- State FUNC:
  - byte==FUNC_BASE+pkg_idx (8-bit add): sum+=byte, byte_idx<=0, go PAYLOAD.
  - Else: func_err_cnt++ (saturating), pkg_idx<=0, go HUNT.
  - A mismatched byte that equals START_BYTE is not re-used as a start.
- State PAYLOAD:
  - Shift the byte into the internal shift register from the LSB end; sum+=byte; byte_idx++.
  - After byte_idx reaches PACKAGE_SIZE-4 (the 8th payload byte), go CHECK.
  - START_BYTE inside the payload is treated as data.
- State CHECK:
  - byte==sum[7:0] (sum is mod 256 over the 10 preceding bytes):
    - If pkg_idx==PACKAGE_NUM-1, go EMIT.
    - Else pkg_idx++ and go HUNT.
  - Mismatch: chk_err_cnt++ (saturating), pkg_idx<=0, shift register contents abandoned, go HUNT.
- State EMIT (exactly one cycle):
  - win_data_o<=shift register, win_wen_o<=1, frame_cnt++ (wraps from 2^CNT_WIDTH-1 to 0), pkg_idx<=0, go HUNT.
  - No pop is issued in EMIT.
- Output register behaviour:
  - win_data_o holds its value until the next EMIT.
  - win_wen_o is registered, is never high two cycles in a row, and is high in the cycle after the final checksum byte is consumed.
- Word layout: package 0 payload byte 0 lands in win_data_o[255:248]; package 3 payload byte 7 lands in [7:0].
- Latency: win_wen_o rises 1 cycle after the vld cycle of the last checksum byte.
- Empty FIFO mid-package: state holds indefinitely; there is no timeout.
- Unused state encodings fall back to HUNT with pkg_idx=0.

Optional Feature:
- Macro: PACKAGE_FRAMER_CHKSUM_EN.
- Defined: CHECK compares the checksum as above, and chk_err_cnt_o counts mismatches.
- Undefined:
  - The checksum byte is consumed and ignored; CHECK always takes the match path.
  - chk_err_cnt_o is tied to 0.
  - The sum adder is not synthesised.

Test Plan:
- Reset, then 4 valid packages (func 51..54, payload bytes 00..1F, correct checksums) -> one win_wen_o pulse; win_data_o=256'h0001..1F; frame_cnt_o=1; both error counters 0.
- Garbage bytes 12,34,AA before a valid 44-byte set -> garbage discarded; same single word emitted; no error counts.
- Package 1 sent with func 53 -> func_err_cnt_o=1; no wen; a following full valid 4-package set emits exactly one word.
- Package 2 checksum corrupted (xor 01) with CHKSUM_EN defined -> chk_err_cnt_o=1, no wen. Same stimulus with the macro undefined -> word emitted, count 0.
- FIFO goes empty for 50 cycles mid-payload, then resumes -> fifo_r_en stays 0 while empty; the word is emitted correctly with no errors.
- rst_n=0 for 1 cycle after package 2's CHECK -> all outputs 0; the next 4 valid packages emit one word; frame_cnt_o=1.
